// File: rtl/race_control_multi.sv
// N-player race controller: sequences draws over one shared
// draw-engine handshake, owns lanes/progress, declares a winner.
module race_control_multi #(
  parameter int N_PLAYERS = 2,
  parameter int PW        = 3,
  parameter int NUM_LANES = 5,
  parameter int LANE_W    = 3,
  parameter int PROG_W    = 8,
  parameter int RACE_LEN  = 200
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         straight,
  input  logic [N_PLAYERS-1:0]         left,
  input  logic [N_PLAYERS-1:0]         right,
  input  logic                         oneframe,
  input  logic                         draw_done,
  output logic                         draw_req,
  output logic [2:0]                   draw_op,
  output logic [PW-1:0]                draw_player,
  output logic [N_PLAYERS*LANE_W-1:0]  lane_out,
  output logic [N_PLAYERS*PROG_W-1:0]  progress_out,
  output logic [PW-1:0]                winner,
  output logic                         winner_valid,
  output logic                         racing,
  output logic                         resetsignal
);

  typedef enum logic [3:0] {
    S_RESET, S_MENU, S_MENU_WAIT, S_START,
    S_BG, S_CAR, S_CHECK, S_WAIT,
    S_CLEAR, S_UPDATE, S_WIN, S_WIN_HOLD
  } state_t;

  localparam logic [2:0] OP_MENU  = 3'd0;
  localparam logic [2:0] OP_BG    = 3'd1;
  localparam logic [2:0] OP_CAR   = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_WIN   = 3'd4;

  localparam logic [PW-1:0]     LAST = PW'(N_PLAYERS - 1);
  localparam logic [LANE_W-1:0] MID  = LANE_W'(NUM_LANES / 2);
  localparam logic [LANE_W-1:0] MAXL = LANE_W'(NUM_LANES - 1);
  localparam logic [PROG_W-1:0] GOAL = PROG_W'(RACE_LEN);

  state_t              state, state_n;
  logic [PW-1:0]       p, p_n;
  logic                done;
  logic                hit;
  logic [PW-1:0]       hit_idx;
  logic                req_n;
  logic [2:0]          op_n;
  logic [PW-1:0]       pl_n;
  logic                racing_n;

  logic [N_PLAYERS-1:0] prev_l, prev_r;
  logic [N_PLAYERS-1:0] pend_l, pend_r;
  logic [N_PLAYERS-1:0] rise_l, rise_r;
  logic [LANE_W-1:0]    lane_q [N_PLAYERS];
  logic [PROG_W-1:0]    prog_q [N_PLAYERS];

  // A completion only counts while a request is actually up.
  assign done   = draw_done & draw_req;
  assign rise_l = left & ~prev_l;
  assign rise_r = right & ~prev_r;

  // Lowest-indexed player sitting on the finish value wins ties.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (prog_q[i] == GOAL) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Next-state and player-index sequencing.
  always_comb begin
    state_n = state;
    p_n     = p;
    unique case (state)
      S_RESET:     state_n = S_MENU;
      S_MENU:      if (done) state_n = S_MENU_WAIT;
      S_MENU_WAIT: if (start) state_n = S_START;
      S_START:     state_n = S_BG;
      S_BG: begin
        if (done) begin
          state_n = S_CAR;
          p_n     = '0;
        end
      end
      S_CAR: begin
        if (done) begin
          if (p == LAST) state_n = S_CHECK;
          else           p_n = p + PW'(1);
        end
      end
      S_CHECK:     state_n = hit ? S_WIN : S_WAIT;
      S_WAIT: begin
        if (!start) begin
          state_n = S_RESET;
        end else if (oneframe) begin
          state_n = S_CLEAR;
          p_n     = '0;
        end
      end
      S_CLEAR: begin
        if (done) begin
          if (p == LAST) state_n = S_UPDATE;
          else           p_n = p + PW'(1);
        end
      end
      S_UPDATE: begin
        state_n = S_CAR;
        p_n     = '0;
      end
      S_WIN:       if (done) state_n = S_WIN_HOLD;
      S_WIN_HOLD:  if (!start) state_n = S_RESET;
      default:     state_n = S_RESET;
    endcase
  end

  // Moore output decode of the upcoming state, registered below.
  always_comb begin
    req_n = 1'b0;
    op_n  = OP_MENU;
    pl_n  = '0;
    unique case (state_n)
      S_MENU: begin
        req_n = 1'b1;
        op_n  = OP_MENU;
      end
      S_BG: begin
        req_n = 1'b1;
        op_n  = OP_BG;
      end
      S_CAR: begin
        req_n = 1'b1;
        op_n  = OP_CAR;
        pl_n  = p_n;
      end
      S_CLEAR: begin
        req_n = 1'b1;
        op_n  = OP_CLEAR;
        pl_n  = p_n;
      end
      S_WIN: begin
        req_n = 1'b1;
        op_n  = OP_WIN;
      end
      default: ;
    endcase
    racing_n = state_n inside
      {S_BG, S_CAR, S_WAIT, S_CLEAR, S_UPDATE};
  end

  // FSM state, registered outputs and winner latch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_RESET;
      p            <= '0;
      draw_req     <= 1'b0;
      draw_op      <= OP_MENU;
      draw_player  <= '0;
      racing       <= 1'b0;
      resetsignal  <= 1'b1;
      winner       <= '0;
      winner_valid <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      draw_req    <= req_n;
      draw_op     <= op_n;
      draw_player <= pl_n;
      racing      <= racing_n;
      resetsignal <= (state_n == S_RESET);
      if (state_n == S_RESET) begin
        winner       <= '0;
        winner_valid <= 1'b0;
      end else if (state == S_START) begin
        winner_valid <= 1'b0;
      end else if (state == S_CHECK && hit) begin
        winner       <= hit_idx;
        winner_valid <= 1'b1;
      end
    end
  end

  // Button edge capture; a new edge beats the per-frame clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_l <= '0;
      prev_r <= '0;
      pend_l <= '0;
      pend_r <= '0;
    end else begin
      prev_l <= left;
      prev_r <= right;
      if (state == S_START || state == S_UPDATE) begin
        pend_l <= rise_l;
        pend_r <= rise_r;
      end else begin
        pend_l <= pend_l | rise_l;
        pend_r <= pend_r | rise_r;
      end
    end
  end

  // Per-player lane and progress, all updated in parallel.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        lane_q[i] <= MID;
        prog_q[i] <= '0;
      end
    end else if (state == S_START) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        lane_q[i] <= MID;
        prog_q[i] <= '0;
      end
    end else if (state == S_UPDATE) begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (pend_l[i] && !pend_r[i] && lane_q[i] != '0)
          lane_q[i] <= lane_q[i] - LANE_W'(1);
        else if (pend_r[i] && !pend_l[i] && lane_q[i] != MAXL)
          lane_q[i] <= lane_q[i] + LANE_W'(1);
        if (straight[i] && prog_q[i] != GOAL)
          prog_q[i] <= prog_q[i] + PROG_W'(1);
      end
    end
  end

  // Flatten per-player state, player 0 in the LSBs.
  always_comb begin
    lane_out     = '0;
    progress_out = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      lane_out[i*LANE_W +: LANE_W]     = lane_q[i];
      progress_out[i*PROG_W +: PROG_W] = prog_q[i];
    end
  end

endmodule

// File: tb/tb_race_control_multi.sv
// Directed bench for race_control_multi: menu flow, steering,
// saturation, race win, abort and async reset mid-draw.
module tb_race_control_multi;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [1:0] straight;
  logic [1:0] left;
  logic [1:0] right;
  logic       oneframe;
  logic       draw_done;
  logic       draw_req;
  logic [2:0] draw_op;
  logic [2:0] draw_player;
  logic [5:0] lane_out;
  logic [15:0] progress_out;
  logic [2:0] winner;
  logic       winner_valid;
  logic       racing;
  logic       resetsignal;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  logic [5:0] log_q[$];

  race_control_multi #(
    .N_PLAYERS(2), .PW(3), .NUM_LANES(5),
    .LANE_W(3), .PROG_W(8), .RACE_LEN(4)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .straight(straight), .left(left), .right(right),
    .oneframe(oneframe), .draw_done(draw_done),
    .draw_req(draw_req), .draw_op(draw_op),
    .draw_player(draw_player), .lane_out(lane_out),
    .progress_out(progress_out), .winner(winner),
    .winner_valid(winner_valid), .racing(racing),
    .resetsignal(resetsignal)
  );

  always #5 clock = ~clock;

  // Draw engine: completes each request in its third cycle.
  initial begin
    draw_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetn || !draw_req) begin
        cnt = 0;
        draw_done = 1'b0;
      end else begin
        cnt++;
        if (cnt == 3) begin
          draw_done = 1'b1;
          log_q.push_back({draw_op, draw_player});
          cnt = 0;
        end else begin
          draw_done = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int run = 0;
    int n = 0;
    while (run < 2 && n < 400) begin
      @(negedge clock);
      n++;
      if (racing && !draw_req) run++;
      else run = 0;
    end
    if (run < 2) begin
      total++; bad++;
      $display("FAIL %s idle timeout got=%0d want=2", nm, run);
    end
  endtask

  task automatic frame(input string nm);
    @(negedge clock) oneframe = 1'b1;
    @(negedge clock) oneframe = 1'b0;
    wait_idle(nm);
  endtask

  task automatic wait_op(input string nm, input logic [2:0] op,
                         input logic [2:0] pl);
    int n = 0;
    while (!(draw_req && draw_op == op && draw_player == pl) && n < 400) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s op timeout got=%0d want=%0d", nm, draw_op, op);
    end
  endtask

  task automatic test_reset;
    logic [5:0] exp [4];
    exp[0] = {3'd0, 3'd0};
    exp[1] = {3'd1, 3'd0};
    exp[2] = {3'd2, 3'd0};
    exp[3] = {3'd2, 3'd1};
    resetn = 1'b0; start = 1'b0; straight = '0;
    left = '0; right = '0; oneframe = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (resetsignal !== 1'b1) begin bad++;
      $display("FAIL rst_sig got=%0b want=1", resetsignal); end
    total++;
    if (draw_req !== 1'b0) begin bad++;
      $display("FAIL rst_req got=%0b want=0", draw_req); end
    total++;
    if (lane_out !== 6'o22) begin bad++;
      $display("FAIL rst_lane got=%0o want=22", lane_out); end
    total++;
    if (progress_out !== 16'h0 || winner_valid !== 1'b0 ||
        racing !== 1'b0) begin bad++;
      $display("FAIL rst_misc got=%0h/%0b/%0b want=0/0/0",
               progress_out, winner_valid, racing); end
    log_q.delete();
    resetn = 1'b1;
    @(negedge clock);
    total++;
    if (draw_req !== 1'b1 || draw_op !== 3'd0 || resetsignal !== 1'b0)
    begin bad++;
      $display("FAIL menu got=%0b/%0d/%0b want=1/0/0",
               draw_req, draw_op, resetsignal); end
    start = 1'b1;
    wait_idle("menu_flow");
    total++;
    if (log_q.size() != 4) begin bad++;
      $display("FAIL seq_len got=%0d want=4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== exp[i]) begin bad++;
        $display("FAIL seq_%0d got=%0h want=%0h", i,
                 (i < log_q.size()) ? log_q[i] : 6'h3f, exp[i]); end
    end
  endtask

  task automatic test_steer;
    @(negedge clock) left[0] = 1'b1;
    repeat (3) frame("steer");
    total++;
    if (lane_out[2:0] !== 3'd1 || lane_out[5:3] !== 3'd2) begin bad++;
      $display("FAIL steer_hold got=%0o want=21", lane_out); end
    left[0] = 1'b0;
    @(negedge clock) begin left[1] = 1'b1; right[1] = 1'b1; end
    @(negedge clock) begin left[1] = 1'b0; right[1] = 1'b0; end
    frame("both");
    total++;
    if (lane_out[5:3] !== 3'd2) begin bad++;
      $display("FAIL steer_both got=%0d want=2", lane_out[5:3]); end
    frame("both_clr");
    total++;
    if (lane_out !== 6'o21) begin bad++;
      $display("FAIL steer_clr got=%0o want=21", lane_out); end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock) right[1] = 1'b1;
      @(negedge clock) right[1] = 1'b0;
      frame("sat_r");
      total++;
      if (lane_out[5:3] > 3'd4) begin bad++;
        $display("FAIL sat_r_%0d got=%0d want<=4", k, lane_out[5:3]); end
    end
    total++;
    if (lane_out[5:3] !== 3'd4) begin bad++;
      $display("FAIL sat_hi got=%0d want=4", lane_out[5:3]); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock) left[0] = 1'b1;
      @(negedge clock) left[0] = 1'b0;
      frame("sat_l");
    end
    total++;
    if (lane_out[2:0] !== 3'd0) begin bad++;
      $display("FAIL sat_lo got=%0d want=0", lane_out[2:0]); end
  endtask

  task automatic test_ignore_frame;
    straight = 2'b01;
    log_q.delete();
    @(negedge clock) oneframe = 1'b1;
    @(negedge clock) oneframe = 1'b0;
    wait_op("car_wait", 3'd2, 3'd0);
    oneframe = 1'b1;
    @(negedge clock) oneframe = 1'b0;
    wait_idle("ign");
    straight = 2'b00;
    repeat (20) @(negedge clock);
    total++;
    if (log_q.size() != 4) begin bad++;
      $display("FAIL ign_ops got=%0d want=4", log_q.size()); end
    total++;
    if (progress_out !== 16'h0001 || !racing || draw_req) begin bad++;
      $display("FAIL ign_prog got=%0h want=0001", progress_out); end
  endtask

  task automatic test_abort;
    @(negedge clock) start = 1'b0;
    @(negedge clock);
    total++;
    if (resetsignal !== 1'b1 || racing !== 1'b0) begin bad++;
      $display("FAIL abort_rst got=%0b/%0b want=1/0",
               resetsignal, racing); end
    @(negedge clock);
    total++;
    if (draw_req !== 1'b1 || draw_op !== 3'd0) begin bad++;
      $display("FAIL abort_menu got=%0b/%0d want=1/0",
               draw_req, draw_op); end
    start = 1'b1;
    wait_idle("restart");
    total++;
    if (lane_out !== 6'o22 || progress_out !== 16'h0) begin bad++;
      $display("FAIL restart got=%0o/%0h want=22/0",
               lane_out, progress_out); end
  endtask

  task automatic test_race;
    int n = 0;
    straight = 2'b11;
    repeat (3) frame("race");
    total++;
    if (progress_out !== 16'h0303 || winner_valid !== 1'b0) begin bad++;
      $display("FAIL race3 got=%0h/%0b want=0303/0",
               progress_out, winner_valid); end
    @(negedge clock) oneframe = 1'b1;
    @(negedge clock) oneframe = 1'b0;
    wait_op("win_wait", 3'd4, 3'd0);
    total++;
    if (progress_out !== 16'h0404) begin bad++;
      $display("FAIL race4 got=%0h want=0404", progress_out); end
    total++;
    if (winner !== 3'd0 || winner_valid !== 1'b1) begin bad++;
      $display("FAIL winner got=%0d/%0b want=0/1",
               winner, winner_valid); end
    while (draw_req && n < 50) begin @(negedge clock); n++; end
    total++;
    if (draw_req !== 1'b0 || winner_valid !== 1'b1) begin bad++;
      $display("FAIL win_hold got=%0b/%0b want=0/1",
               draw_req, winner_valid); end
    straight = 2'b00;
    repeat (3) @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    total++;
    if (resetsignal !== 1'b1 || winner_valid !== 1'b0) begin bad++;
      $display("FAIL win_rst got=%0b/%0b want=1/0",
               resetsignal, winner_valid); end
    start = 1'b1;
    wait_idle("race_restart");
  endtask

  task automatic test_async_reset;
    straight = 2'b01;
    @(negedge clock) left[0] = 1'b1;
    @(negedge clock) left[0] = 1'b0;
    frame("pre_async");
    total++;
    if (lane_out !== 6'o21 || progress_out !== 16'h0001) begin bad++;
      $display("FAIL pre_async got=%0o/%0h want=21/0001",
               lane_out, progress_out); end
    @(negedge clock) oneframe = 1'b1;
    @(negedge clock) oneframe = 1'b0;
    wait_op("clr1_wait", 3'd3, 3'd1);
    #2 resetn = 1'b0;
    #1;
    total++;
    if (draw_req !== 1'b0 || resetsignal !== 1'b1) begin bad++;
      $display("FAIL async_req got=%0b/%0b want=0/1",
               draw_req, resetsignal); end
    total++;
    if (lane_out !== 6'o22 || progress_out !== 16'h0) begin bad++;
      $display("FAIL async_state got=%0o/%0h want=22/0",
               lane_out, progress_out); end
    straight = 2'b00;
    @(negedge clock) resetn = 1'b1;
    wait_idle("post_async");
  endtask

  initial begin
    test_reset();
    test_steer();
    test_saturate();
    test_ignore_frame();
    test_abort();
    test_race();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
